// File: rtl/block_data_memory.sv
// rtl/block_data_memory.sv - multi-cycle 32-bit block store behind a level BUSY handshake
module block_data_memory #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [5:0]  ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        busy_fsm;
  logic        req;
  logic        commit;
  logic [7:0]  counter;
  logic [5:0]  addr_lat;
  logic [31:0] data_lat;
  logic        write_lat;
  logic [31:0] mem [DEPTH];

  assign req    = READ | WRITE;
  assign commit = (state == ACCESS) && (counter == 8'd0);
  // Requester may hold READ/WRITE through reset; BUSY must still read low.
  assign BUSY   = RESET & busy_fsm;

  always_comb begin
    state_next = state;
    busy_fsm   = 1'b0;
    case (state)
      IDLE: begin
        busy_fsm = req;
        if (req) state_next = ACCESS;
      end
      ACCESS: begin
        busy_fsm = 1'b1;
        if (counter == 8'd0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      counter   <= 8'd0;
      addr_lat  <= 6'd0;
      data_lat  <= 32'd0;
      write_lat <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req) begin
            addr_lat  <= ADDRESS;
            data_lat  <= WRITEDATA;
            write_lat <= WRITE;
            counter   <= 8'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (counter != 8'd0) counter <= counter - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Commit happens on the DONE entry edge, so an aborted access never writes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      READDATA <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (commit) begin
      if (write_lat) mem[addr_lat] <= data_lat;
      else           READDATA      <= mem[addr_lat];
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// tb/tb_block_data_memory.sv - vector, directed and randomized checks for block_data_memory
module tb_block_data_memory;

  localparam int LAT0 = 5;
  localparam int LAT1 = 1;

  logic        CLK;
  logic        RESET;
  logic        read0, write0, busy0;
  logic [5:0]  address0;
  logic [31:0] writedata0, readdata0;
  logic        read1, write1, busy1;
  logic [5:0]  address1;
  logic [31:0] writedata1, readdata1;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] ref_rd;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  block_data_memory #(.LATENCY(LAT0), .DEPTH(64)) dut_l5 (
    .CLK(CLK), .RESET(RESET), .READ(read0), .WRITE(write0),
    .ADDRESS(address0), .WRITEDATA(writedata0),
    .READDATA(readdata0), .BUSY(busy0)
  );

  block_data_memory #(.LATENCY(LAT1), .DEPTH(64)) dut_l1 (
    .CLK(CLK), .RESET(RESET), .READ(read1), .WRITE(write1),
    .ADDRESS(address1), .WRITEDATA(writedata1),
    .READDATA(readdata1), .BUSY(busy1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic cur_busy(input int which);
    return (which == 0) ? busy0 : busy1;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    ref_rd = 32'd0;
  endtask

  task automatic ref_apply(input bit wr, input logic [5:0] a, input logic [31:0] d);
    if (wr) ref_mem[a] = d;
    else    ref_rd     = ref_mem[a];
  endtask

  // Width = number of negedge samples with BUSY high, starting in the request cycle.
  task automatic access(input int which, input bit rd, input bit wr,
                        input logic [5:0] a, input logic [31:0] d, output int width);
    @(posedge CLK); #1;
    if (which == 0) begin
      read0 = rd; write0 = wr; address0 = a; writedata0 = d;
    end else begin
      read1 = rd; write1 = wr; address1 = a; writedata1 = d;
    end
    width = 0;
    @(negedge CLK);
    while (cur_busy(which) && width < 300) begin
      width++;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    if (which == 0) begin read0 = 1'b0; write0 = 1'b0; end
    else            begin read1 = 1'b0; write1 = 1'b0; end
  endtask

  initial begin
    int w;
    int op;
    logic [5:0]  a;
    logic [31:0] d;

    vecs[0] = '{1'b1, 1'b0, 6'd10, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b1, 6'd5,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 6'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 6'd63, 32'h11223344, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 6'd0,  32'hAABBCCDD, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 6'd63, 32'h0,        32'h11223344};
    vecs[6] = '{1'b1, 1'b0, 6'd0,  32'h0,        32'hAABBCCDD};
    vecs[7] = '{1'b1, 1'b0, 6'd62, 32'h0,        32'h0};
    vecs[8] = '{1'b1, 1'b1, 6'd7,  32'h12345678, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 6'd7,  32'h0,        32'h12345678};

    RESET = 1'b0;
    read0 = 1'b1; write0 = 1'b0; address0 = 6'd0; writedata0 = 32'd0;
    read1 = 1'b0; write1 = 1'b0; address1 = 6'd0; writedata1 = 32'd0;
    ref_clear();
    @(negedge CLK);
    @(negedge CLK);
    check32("busy_in_reset", {31'd0, busy0}, 32'd0);
    check32("readdata_reset", readdata0, 32'd0);
    read0 = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    check32("busy_idle", {31'd0, busy0}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, w);
      ref_apply(vecs[i].wr, vecs[i].addr, vecs[i].data);
      check32($sformatf("vec%0d_busy_width", i), w, LAT0 + 1);
      check32($sformatf("vec%0d_readdata", i), readdata0, vecs[i].exp_rd);
    end

    // Reset during ACCESS cycle 2 aborts the write.
    @(posedge CLK); #1;
    write0 = 1'b1; address0 = 6'd3; writedata0 = 32'hCAFEF00D;
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    check32("abort_busy", {31'd0, busy0}, 32'd0);
    check32("abort_readdata", readdata0, 32'd0);
    @(negedge CLK);
    write0 = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    ref_clear();
    access(0, 1'b1, 1'b0, 6'd3, 32'h0, w);
    check32("abort_no_commit", readdata0, 32'h0);
    access(0, 1'b1, 1'b0, 6'd5, 32'h0, w);
    check32("reset_clears_mem", readdata0, 32'h0);

    // Address change mid-ACCESS is ignored.
    access(0, 1'b0, 1'b1, 6'd9,  32'h0000ABCD, w);
    access(0, 1'b0, 1'b1, 6'd20, 32'h5555AAAA, w);
    ref_apply(1'b1, 6'd9,  32'h0000ABCD);
    ref_apply(1'b1, 6'd20, 32'h5555AAAA);
    @(posedge CLK); #1;
    read0 = 1'b1; address0 = 6'd9;
    w = 0;
    @(negedge CLK);
    while (busy0 && w < 300) begin
      w++;
      if (w == 2) begin address0 = 6'd20; writedata0 = 32'hFFFFFFFF; end
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    read0 = 1'b0;
    ref_apply(1'b0, 6'd9, 32'h0);
    check32("addr_change_width", w, LAT0 + 1);
    check32("addr_change_readdata", readdata0, 32'h0000ABCD);

    access(1, 1'b0, 1'b1, 6'd12, 32'h00000077, w);
    check32("l1_write_width", w, LAT1 + 1);
    check32("l1_write_readdata", readdata1, 32'h0);
    access(1, 1'b1, 1'b0, 6'd12, 32'h0, w);
    check32("l1_read_width", w, LAT1 + 1);
    check32("l1_read_readdata", readdata1, 32'h00000077);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a  = 6'($urandom_range(0, 15));
      d  = $urandom;
      access(0, op != 1, op != 0, a, d, w);
      ref_apply(op != 0, a, d);
      check32($sformatf("rand%0d_width", i), w, LAT0 + 1);
      check32($sformatf("rand%0d_readdata", i), readdata0, ref_rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Word-block backing store directly downstream of the 8-bit CPU's data cache.
- Serves block refills (READ) and dirty-block write-backs (WRITE) of 32-bit blocks addressed by a 6-bit block address ({tag,index}).
- Models multi-cycle memory latency behind a level BUSY handshake.
- The cache FSM holds READ/WRITE until it sees BUSY low.

Parameters:
LATENCY, 5, number of cycles spent in ACCESS before completion (legal range 1..255)
DEPTH, 64, number of 32-bit blocks (must equal 2^6)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset (asserted when 0)
READ  input  1  block read request, level, held by requester until BUSY=0
WRITE  input  1  block write request, level, held by requester until BUSY=0
ADDRESS  input  6  block address
WRITEDATA  input  32  block to store (byte 0 = bits 7:0)
READDATA  output  32  block returned for a read, registered
BUSY  output  1  access in progress; requester must hold inputs stable while high

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, counter=0, READDATA=0, all DEPTH blocks cleared to 0. Reset mid-access aborts it with no write commit. BUSY=0 while in reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - BUSY is combinational = READ|WRITE, so it rises in the same cycle the request appears.
  - On an edge with READ|WRITE=1: latch ADDRESS, WRITEDATA and op into registers, set counter=LATENCY-1, go to ACCESS.
- ACCESS:
  - BUSY=1.
  - Each edge decrements counter; on the edge where counter==0, go to DONE.
  - ACCESS therefore lasts exactly LATENCY cycles.
  - Input changes during ACCESS are ignored (latched copies are used).
- DONE entry edge:
  - Read: READDATA <= mem[latched addr].
  - Write: mem[latched addr] <= latched data; READDATA unchanged.
- DONE: BUSY=0 for exactly one cycle, then return to IDLE unconditionally. The request level is not sampled in DONE.
- Total: request visible in cycle 0 → BUSY low in cycle LATENCY+1. The requester drops READ/WRITE on the edge ending DONE.
- If READ/WRITE is still high in IDLE after DONE, it is a new request and is accepted.
- READ and WRITE both high: WRITE wins; treated as a single write access.
- READDATA holds its last read value indefinitely, including across writes, until the next read completes.
- Address uses all 6 bits; no wrap or out-of-range case exists.
- Write then read of the same address returns the new data (write commits before the following IDLE).

Test Plan:
1. Reset low for 2 cycles then high; READ addr 6'd10 → BUSY high from the request cycle, low in cycle LATENCY+1 (6 with default); READDATA=32'h0.
2. WRITE addr 6'd5 data 32'hDEADBEEF, then READ addr 6'd5 → READDATA=32'hDEADBEEF; BUSY pulse width is 6 cycles for each access.
3. Write 32'h11223344 to addr 63 and 32'hAABBCCDD to addr 0, then read both → correct data each; addr 62 still reads 32'h0.
4. READ and WRITE asserted together, addr 7, data 32'h12345678 → acts as write; a later read of addr 7 returns 32'h12345678; READDATA unchanged after the combined access.
5. WRITE addr 3 data 32'hCAFEF00D; pull RESET low at ACCESS cycle 2 → BUSY=0 and READDATA=0 immediately; read of addr 3 after reset returns 32'h0.
6. Start READ addr 9 (preloaded 32'h0000ABCD), change ADDRESS to 20 mid-ACCESS → READDATA=32'h0000ABCD; rerun with LATENCY=1 → BUSY high for exactly 2 cycles.
